// File: rtl/result_readout.sv
// result_readout: reader side of the result memory.
//
// On a start request in idle, snapshots the twelve stored 2x2 results (PE, 3x3 SA and
// 2x2 SA; C11, C12, C21, C22 each). It also records which elements disagree across the
// three engines. It then streams the snapshot out as twelve tagged beats over a
// valid/ready interface, source-major (all PE, then 3x3 SA, then 2x2 SA).
//
// Ports:
//   clk, rst_readout        clock; asynchronous active-low reset
//   start                   request one frame (sampled only when idle)
//   mem_C*_PE/3by3/2by2     live result memory contents, DATA_W each
//   out_data/out_valid      beat value and valid
//   out_ready               downstream accepts beat
//   out_src                 0 = PE, 1 = 3x3 SA, 2 = 2x2 SA
//   out_idx                 0 = C11, 1 = C12, 2 = C21, 3 = C22
//   out_last                final beat of the frame
//   busy, done              frame in progress; one-cycle completion pulse
//   mismatch_mask/mismatch  per-element cross-engine disagreement, held until next capture
module result_readout #(
    parameter int unsigned DATA_W = 8,
    parameter bit          CMP_EN = 1'b1
) (
    input  logic              clk,
    input  logic              rst_readout,
    input  logic              start,
    input  logic [DATA_W-1:0] mem_C11_PE,
    input  logic [DATA_W-1:0] mem_C12_PE,
    input  logic [DATA_W-1:0] mem_C21_PE,
    input  logic [DATA_W-1:0] mem_C22_PE,
    input  logic [DATA_W-1:0] mem_C11_3by3,
    input  logic [DATA_W-1:0] mem_C12_3by3,
    input  logic [DATA_W-1:0] mem_C21_3by3,
    input  logic [DATA_W-1:0] mem_C22_3by3,
    input  logic [DATA_W-1:0] mem_C11_2by2,
    input  logic [DATA_W-1:0] mem_C12_2by2,
    input  logic [DATA_W-1:0] mem_C21_2by2,
    input  logic [DATA_W-1:0] mem_C22_2by2,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [1:0]        out_src,
    output logic [1:0]        out_idx,
    output logic              out_last,
    output logic              busy,
    output logic              done,
    output logic [3:0]        mismatch_mask,
    output logic              mismatch
);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StSend = 2'd1,
        StDone = 2'd2
    } state_e;

    state_e            r_state;
    state_e            w_state_next;
    logic [3:0]        r_cnt;
    logic [3:0]        w_cnt_next;
    logic [DATA_W-1:0] r_shadow [12];
    logic [DATA_W-1:0] w_mem [12];
    logic [3:0]        r_mask;
    logic [3:0]        w_mask;
    logic              w_capture;
    logic              w_last;

    // Flat view of the memory in beat order: index = src * 4 + idx.
    always_comb begin
        w_mem[0]  = mem_C11_PE;
        w_mem[1]  = mem_C12_PE;
        w_mem[2]  = mem_C21_PE;
        w_mem[3]  = mem_C22_PE;
        w_mem[4]  = mem_C11_3by3;
        w_mem[5]  = mem_C12_3by3;
        w_mem[6]  = mem_C21_3by3;
        w_mem[7]  = mem_C22_3by3;
        w_mem[8]  = mem_C11_2by2;
        w_mem[9]  = mem_C12_2by2;
        w_mem[10] = mem_C21_2by2;
        w_mem[11] = mem_C22_2by2;
    end

    // Element i mismatches unless all three engines agree exactly.
    always_comb begin
        w_mask = '0;
        if (CMP_EN) begin
            for (int i = 0; i < 4; i++) begin
                w_mask[i] = !((w_mem[i] == w_mem[i+4]) && (w_mem[i+4] == w_mem[i+8]));
            end
        end
    end

    assign w_capture = (r_state == StIdle) && start;
    assign w_last    = (r_cnt == 4'd11);

    // Next-state and beat counter.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        unique case (r_state)
            StIdle: begin
                if (start) begin
                    w_state_next = StSend;
                    w_cnt_next   = 4'd0;
                end
            end
            StSend: begin
                if (out_ready) begin
                    if (w_last) begin
                        w_state_next = StDone;
                        w_cnt_next   = 4'd0;
                    end else begin
                        w_cnt_next = r_cnt + 4'd1;
                    end
                end
            end
            StDone: begin
                w_state_next = StIdle;
            end
            default: begin
                w_state_next = StIdle;
                w_cnt_next   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_readout) begin
        if (!rst_readout) begin
            r_state <= StIdle;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    // Snapshot and mask change only at capture, so memory writes mid-frame are invisible.
    always_ff @(posedge clk or negedge rst_readout) begin
        if (!rst_readout) begin
            for (int i = 0; i < 12; i++) begin
                r_shadow[i] <= '0;
            end
            r_mask <= 4'd0;
        end else if (w_capture) begin
            for (int i = 0; i < 12; i++) begin
                r_shadow[i] <= w_mem[i];
            end
            r_mask <= w_mask;
        end
    end

    // Beat outputs are a pure function of the held counter, hence stable under backpressure.
    always_comb begin
        out_valid = (r_state == StSend);
        out_data  = '0;
        out_src   = 2'd0;
        out_idx   = 2'd0;
        out_last  = 1'b0;
        if (out_valid) begin
            out_data = r_shadow[r_cnt];
            out_src  = r_cnt[3:2];
            out_idx  = r_cnt[1:0];
            out_last = w_last;
        end
    end

    assign busy          = (r_state != StIdle);
    assign done          = (r_state == StDone);
    assign mismatch_mask = r_mask;
    assign mismatch      = |r_mask;

endmodule

// File: tb/tb_result_readout.sv
// Randomised self-checking bench for result_readout. A small reference model builds the
// expected beat list and mismatch mask straight from the captured memory values.
module tb_result_readout;

    logic       clk;
    logic       rst_readout;
    logic       start;
    logic [7:0] m_pe [4];
    logic [7:0] m_s3 [4];
    logic [7:0] m_s2 [4];
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic [1:0] out_src;
    logic [1:0] out_idx;
    logic       out_last;
    logic       busy;
    logic       done;
    logic [3:0] mismatch_mask;
    logic       mismatch;

    int n_tests;
    int n_fail;

    // Reference model state: expected frame and mask for the current capture.
    logic [7:0] exp_beats [12];
    logic [3:0] exp_mask;

    result_readout #(
        .DATA_W(8),
        .CMP_EN(1'b1)
    ) dut (
        .clk          (clk),
        .rst_readout  (rst_readout),
        .start        (start),
        .mem_C11_PE   (m_pe[0]),
        .mem_C12_PE   (m_pe[1]),
        .mem_C21_PE   (m_pe[2]),
        .mem_C22_PE   (m_pe[3]),
        .mem_C11_3by3 (m_s3[0]),
        .mem_C12_3by3 (m_s3[1]),
        .mem_C21_3by3 (m_s3[2]),
        .mem_C22_3by3 (m_s3[3]),
        .mem_C11_2by2 (m_s2[0]),
        .mem_C12_2by2 (m_s2[1]),
        .mem_C21_2by2 (m_s2[2]),
        .mem_C22_2by2 (m_s2[3]),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_src      (out_src),
        .out_idx      (out_idx),
        .out_last     (out_last),
        .busy         (busy),
        .done         (done),
        .mismatch_mask(mismatch_mask),
        .mismatch     (mismatch)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_mem_random(input int unsigned range_hi);
        for (int i = 0; i < 4; i++) begin
            m_pe[i] = 8'($urandom_range(0, range_hi));
            m_s3[i] = 8'($urandom_range(0, range_hi));
            m_s2[i] = 8'($urandom_range(0, range_hi));
        end
    endtask

    // Model: frame is all PE elements, then 3x3, then 2x2; an element mismatches
    // unless all three copies are equal.
    task automatic model_capture();
        for (int i = 0; i < 4; i++) begin
            exp_beats[i]     = m_pe[i];
            exp_beats[i + 4] = m_s3[i];
            exp_beats[i + 8] = m_s2[i];
            exp_mask[i]      = !(m_pe[i] == m_s3[i] && m_s3[i] == m_s2[i]);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".valid"}, 32'(out_valid), 32'd0);
        check({tag, ".data"}, 32'(out_data), 32'd0);
        check({tag, ".src"}, 32'(out_src), 32'd0);
        check({tag, ".idx"}, 32'(out_idx), 32'd0);
        check({tag, ".last"}, 32'(out_last), 32'd0);
        check({tag, ".busy"}, 32'(busy), 32'd0);
        check({tag, ".done"}, 32'(done), 32'd0);
        check({tag, ".mask"}, 32'(mismatch_mask), 32'd0);
        check({tag, ".mm"}, 32'(mismatch), 32'd0);
    endtask

    // mode 0: ready high; 1: ready 1,0,0 repeating; 2: random ready.
    // abort_at >= 0 asserts reset while that beat is presented and returns.
    task automatic run_frame(input string tag, input int mode, input bit poke_mem,
                             input bit poke_start, input int abort_at);
        int beat;
        model_capture();
        start = 1'b1;
        tick();
        start = 1'b0;
        check({tag, ".cap_busy"}, 32'(busy), 32'd1);
        check({tag, ".cap_mask"}, 32'(mismatch_mask), 32'(exp_mask));
        check({tag, ".cap_mm"}, 32'(mismatch), 32'(exp_mask != 4'd0));
        beat = 0;
        for (int cyc = 0; cyc < 400 && beat < 12; cyc++) begin
            if (abort_at >= 0 && beat == abort_at) begin
                rst_readout = 1'b0;
                #1;
                check({tag, ".rst_valid"}, 32'(out_valid), 32'd0);
                check({tag, ".rst_busy"}, 32'(busy), 32'd0);
                check({tag, ".rst_mm"}, 32'(mismatch), 32'd0);
                check({tag, ".rst_done"}, 32'(done), 32'd0);
                #2;
                rst_readout = 1'b1;
                tick();
                check({tag, ".post_rst_busy"}, 32'(busy), 32'd0);
                check({tag, ".post_rst_done"}, 32'(done), 32'd0);
                return;
            end
            check({tag, ".valid"}, 32'(out_valid), 32'd1);
            check({tag, ".data"}, 32'(out_data), 32'(exp_beats[beat]));
            check({tag, ".src"}, 32'(out_src), 32'(beat / 4));
            check({tag, ".idx"}, 32'(out_idx), 32'(beat % 4));
            check({tag, ".last"}, 32'(out_last), 32'(beat == 11));
            check({tag, ".done_early"}, 32'(done), 32'd0);
            case (mode)
                0:       out_ready = 1'b1;
                1:       out_ready = (cyc % 3 == 0);
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            start = poke_start && (beat == 5);
            if (poke_mem && beat == 3) m_pe[0] = 8'hFF;
            tick();
            if (out_ready) beat++;
        end
        start = 1'b0;
        check({tag, ".beats"}, 32'(beat), 32'd12);
        check({tag, ".end_valid"}, 32'(out_valid), 32'd0);
        check({tag, ".end_last"}, 32'(out_last), 32'd0);
        check({tag, ".done"}, 32'(done), 32'd1);
        check({tag, ".done_busy"}, 32'(busy), 32'd1);
        start = poke_start;
        out_ready = 1'($urandom_range(0, 1));
        tick();
        start = 1'b0;
        check({tag, ".done_pulse"}, 32'(done), 32'd0);
        check({tag, ".idle_busy"}, 32'(busy), 32'd0);
        check({tag, ".idle_valid"}, 32'(out_valid), 32'd0);
        check({tag, ".held_mask"}, 32'(mismatch_mask), 32'(exp_mask));
        tick();
        check({tag, ".no_requeue"}, 32'(busy), 32'd0);
    endtask

    initial begin
        n_tests     = 0;
        n_fail      = 0;
        rst_readout = 1'b0;
        start       = 1'b1;
        out_ready   = 1'b1;
        set_mem_random(255);

        // Reset held with start high: nothing moves.
        repeat (3) tick();
        check_all_zero("reset");
        start = 1'b0;
        #2;
        rst_readout = 1'b1;
        tick();
        tick();
        check_all_zero("release");

        // All three engines agree.
        for (int i = 0; i < 4; i++) begin
            m_pe[i] = 8'h11 + 8'((i / 2) * 16 + (i % 2));
            m_s3[i] = m_pe[i];
            m_s2[i] = m_pe[i];
        end
        run_frame("match", 0, 1'b0, 1'b0, -1);

        // Two disagreeing elements: C12 (PE) and C21 (2x2).
        m_s2[2] = 8'hCC;
        m_pe[1] = 8'hAA;
        run_frame("mismatch", 0, 1'b0, 1'b0, -1);

        // Backpressure with memory overwritten mid-frame.
        set_mem_random(255);
        run_frame("bp", 1, 1'b1, 1'b0, -1);

        // Start pulsed mid-frame and in the done cycle.
        set_mem_random(3);
        run_frame("busy_start", 0, 1'b0, 1'b1, -1);

        // Reset mid-frame on beat 7, then a fresh frame.
        for (int i = 0; i < 4; i++) begin
            m_pe[i] = 8'h40 + 8'(i);
            m_s3[i] = m_pe[i];
            m_s2[i] = m_pe[i] ^ 8'h01;
        end
        run_frame("abort", 0, 1'b0, 1'b0, 7);
        set_mem_random(255);
        run_frame("after_abort", 0, 1'b0, 1'b0, -1);

        // Randomised frames; a small value range makes partial agreement common.
        for (int f = 0; f < 6; f++) begin
            set_mem_random(($urandom_range(0, 1) == 1) ? 2 : 255);
            run_frame("rand", 2, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), -1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/result_readout.md
Name: result_readout

Overview:
- Reader side of the result memory: snapshots the twelve stored 2×2 result registers (PE, 3×3 SA and 2×2 SA; C11, C12, C21, C22 each).
- Cross-checks the three engines element by element and streams the snapshot out over a valid/ready byte interface, one frame per start request.
- Sits between the memory block and the output/display path. Downstream sees a stable, tagged copy even if the engines overwrite memory mid-readout.

Parameters:
- DATA_W, 8: width of each result element and of out_data.
- CMP_EN, 1: 1 = compute mismatch_mask at capture; 0 = mismatch_mask and mismatch held at 0.

Ports:
- clk  input  1  system clock; one clock, all state on rising edge.
- rst_readout  input  1  reset is asynchronous and active-low.
- start  input  1  request one readout frame; sampled only in IDLE.
- mem_C11_PE, mem_C12_PE, mem_C21_PE, mem_C22_PE  input  DATA_W each  PE results.
- mem_C11_3by3, mem_C12_3by3, mem_C21_3by3, mem_C22_3by3  input  DATA_W each  3×3 SA results.
- mem_C11_2by2, mem_C12_2by2, mem_C21_2by2, mem_C22_2by2  input  DATA_W each  2×2 SA results.
- out_data  output  DATA_W  current beat value.
- out_valid  output  1  beat valid.
- out_ready  input  1  downstream accepts beat.
- out_src  output  2  source tag: 0 = PE, 1 = 3×3 SA, 2 = 2×2 SA.
- out_idx  output  2  element tag: 0 = C11, 1 = C12, 2 = C21, 3 = C22.
- out_last  output  1  high on final beat (beat 11).
- busy  output  1  state != IDLE.
- done  output  1  one-cycle pulse after the frame completes.
- mismatch_mask  output  4  bit i set when element i differs across the three sources (bit0 = C11 … bit3 = C22).
- mismatch  output  1  OR of mismatch_mask.

Behaviour:
- **Reset** (rst_readout low, asynchronous): state = IDLE. All outputs 0, shadow registers 0, beat counter 0. Reset mid-frame aborts the frame with no done pulse; the frame does not resume after reset release.
- **States:** IDLE, SEND, DONE.
- **IDLE:**
  - start = 1 at edge k: all 12 inputs captured into shadow registers at edge k, beat counter = 0, state → SEND.
  - out_valid = 1 from edge k onward.
  - mismatch_mask[i] updated at edge k: set iff NOT (PE_i == SA3_i == SA2_i).
  - The mask holds until the next capture.
- **SEND:**
  - Beat n (0..11) is source-major: out_src = n / 4, out_idx = n % 4, out_data = shadow[src][idx].
  - A beat transfers on an edge where out_valid && out_ready; the counter then increments.
  - While out_valid && !out_ready, out_data, out_src, out_idx and out_last are held stable.
  - out_last = 1 only when the counter is 11.
  - Handshake on beat 11 → state DONE, with out_valid = 0 and out_last = 0 after that edge.
- **DONE:** done = 1 for exactly one cycle, busy = 1, then → IDLE.
- **Ignored inputs:**
  - start is ignored in SEND and DONE; it is not queued.
  - Changes on mem_* inputs after capture do not affect the frame.
- **Throughput and latency:**
  - With out_ready held high, beats transfer on 12 consecutive edges.
  - done is high in the cycle after the beat-11 transfer edge.
  - busy drops to 0 one cycle later.
  - A new start is accepted at the first edge where state is IDLE again.
- out_ready with out_valid = 0 has no effect.
- No arithmetic is performed; comparison is an exact DATA_W-bit equality.

Test Plan:
- **Reset values:** hold rst_readout low with start = 1 and random mem_* inputs -> every output 0 and busy = 0. Release reset with start = 0 -> nothing changes.
- **Full frame, ready always high:**
  - Stimulus: PE = {0x11, 0x12, 0x21, 0x22}, SA3 = the same values, SA2 = the same values; pulse start.
  - Required beats: 12 beats 0x11, 0x12, 0x21, 0x22 ×3, with out_src 0,0,0,0,1,1,1,1,2,2,2,2 and out_idx 0..3 repeating.
  - out_last is high on beat 11 only, done pulses one cycle later, mismatch_mask = 0.
- **Mismatch detection:** set mem_C21_2by2 = 0xCC and mem_C12_PE = 0xAA, with all other copies matching -> mismatch_mask = 4'b0110 and mismatch = 1 right after the capture edge. The mask still reads 4'b0110 after done.
- **Backpressure:**
  - Toggle out_ready 1,0,0,1,… -> out_data and tags stay frozen during ready-low cycles, and no beat is lost or duplicated; the frame is still exactly 12 transfers.
  - Change mem_C11_PE to 0xFF mid-frame -> the frame still carries the captured value.
- **Start while busy:** pulse start on beat 5 and again in the DONE cycle -> no restart, the frame completes normally, and exactly one done pulse occurs.
- **Reset mid-frame:** assert rst_readout low during beat 7 -> out_valid, busy and mismatch go to 0 immediately, with no done pulse. A following start produces a fresh 12-beat frame beginning at beat 0.
